quantum_rng_lfsr: RTL and testbench

QUANTUM_RNG_LFSR -- requirements
Module: quantum_rng_lfsr

---
 rtl/quantum_rng_lfsr.sv | 125 ++++++++++++
 tb/tb_quantum_rng_lfsr.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/quantum_rng_lfsr.sv
// Random word generator: a binary counter or Galois LFSR produces one bit per enabled step.
// The bits are packed LSB-first into OUT_W-bit words and handed off through a valid/ready port.
module quantum_rng_lfsr #(
    parameter int unsigned      WIDTH = 16,
    parameter int unsigned      OUT_W = 8,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mode,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             rd_ready,
    input  logic             clear_ovf,
    output logic [OUT_W-1:0] rnd_data,
    output logic             rnd_valid,
    output logic             overrun,
    output logic             gen_bit,
    output logic [WIDTH-1:0] state_out
);

    localparam int unsigned     CntW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(OUT_W - 1);

    logic [WIDTH-1:0] state_q, state_d;
    logic [CntW-1:0]  bitcnt_q, bitcnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] rnd_data_q, rnd_data_d;
    logic             rnd_valid_q, rnd_valid_d;
    logic             overrun_q, overrun_d;

    logic [OUT_W-1:0] word;
    logic             word_done;

    // Generator state, bit counter and accumulator
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        acc_d     = acc_q;
        word      = acc_q;
        word_done = 1'b0;

        if (seed_load) begin
            // A zero seed would lock the LFSR, so it is replaced by 1 in LFSR mode
            if (mode && (seed == '0)) begin
                state_d = WIDTH'(1);
            end else begin
                state_d = seed;
            end
            bitcnt_d = '0;
            acc_d    = '0;
        end else if (enable) begin
            if (!mode) begin
                state_d = state_q + WIDTH'(1);
            end else if (state_q == '0) begin
                state_d = WIDTH'(1);
            end else begin
                state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
            end

            word           = acc_q;
            word[bitcnt_q] = state_q[0];

            if (bitcnt_q == LastBit) begin
                word_done = 1'b1;
                bitcnt_d  = '0;
                acc_d     = '0;
            end else begin
                bitcnt_d = bitcnt_q + CntW'(1);
                acc_d    = word;
            end
        end
    end

    // Output handshake and overrun tracking
    always_comb begin
        rnd_data_d  = rnd_data_q;
        rnd_valid_d = rnd_valid_q;
        overrun_d   = overrun_q;

        if (clear_ovf) begin
            overrun_d = 1'b0;
        end

        if (rnd_valid_q && rd_ready) begin
            rnd_valid_d = 1'b0;
        end

        // A completion is accepted when the slot is empty or drained on this same edge
        if (word_done) begin
            if (!rnd_valid_q || rd_ready) begin
                rnd_data_d  = word;
                rnd_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= '0;
            bitcnt_q    <= '0;
            acc_q       <= '0;
            rnd_data_q  <= '0;
            rnd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            acc_q       <= acc_d;
            rnd_data_q  <= rnd_data_d;
            rnd_valid_q <= rnd_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rnd_data  = rnd_data_q;
    assign rnd_valid = rnd_valid_q;
    assign overrun   = overrun_q;
    assign gen_bit   = state_q[0];
    assign state_out = state_q;

endmodule

// File: tb/tb_quantum_rng_lfsr.sv
// Directed bench for quantum_rng_lfsr with default parameters (WIDTH=16, OUT_W=8, TAPS=16'hB400).
module tb_quantum_rng_lfsr;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        mode;
    logic        seed_load;
    logic [15:0] seed;
    logic        rd_ready;
    logic        clear_ovf;
    logic [7:0]  rnd_data;
    logic        rnd_valid;
    logic        overrun;
    logic        gen_bit;
    logic [15:0] state_out;

    int vectors;
    int miscompares;
    int first_hit;

    quantum_rng_lfsr #(
        .WIDTH(16),
        .OUT_W(8),
        .TAPS (16'hB400)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .mode     (mode),
        .seed_load(seed_load),
        .seed     (seed),
        .rd_ready (rd_ready),
        .clear_ovf(clear_ovf),
        .rnd_data (rnd_data),
        .rnd_valid(rnd_valid),
        .overrun  (overrun),
        .gen_bit  (gen_bit),
        .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        enable      = 1'b0;
        mode        = 1'b0;
        seed_load   = 1'b0;
        seed        = '0;
        rd_ready    = 1'b0;
        clear_ovf   = 1'b0;

        #3;
        check("rst_state", 32'(state_out), 32'h0);
        check("rst_valid", 32'(rnd_valid), 32'h0);
        check("rst_data", 32'(rnd_data), 32'h0);
        check("rst_ovf", 32'(overrun), 32'h0);
        check("rst_genbit", 32'(gen_bit), 32'h0);
        #9;
        rst_n = 1'b1;

        // Counter mode: bits 0,1,0,1,... pack LSB-first into 8'hAA
        step();
        mode     = 1'b0;
        enable   = 1'b1;
        rd_ready = 1'b1;
        steps(7);
        check("cnt_valid_early", 32'(rnd_valid), 32'h0);
        step();
        enable = 1'b0;
        check("cnt_valid", 32'(rnd_valid), 32'h1);
        check("cnt_data", 32'(rnd_data), 32'hAA);
        check("cnt_state", 32'(state_out), 32'h0008);
        step();
        check("cnt_drain", 32'(rnd_valid), 32'h0);

        // LFSR seeding and one step
        mode      = 1'b1;
        seed_load = 1'b1;
        seed      = 16'h0001;
        step();
        seed_load = 1'b0;
        check("seed1_state", 32'(state_out), 32'h0001);
        check("seed1_genbit", 32'(gen_bit), 32'h1);
        enable = 1'b1;
        step();
        enable = 1'b0;
        check("lfsr_step", 32'(state_out), 32'hB400);
        seed_load = 1'b1;
        seed      = 16'h0000;
        step();
        seed_load = 1'b0;
        check("seed0_guard", 32'(state_out), 32'h0001);

        // Lock-up guard from zero, then full period
        pulse_reset();
        check("lock_zero", 32'(state_out), 32'h0);
        enable = 1'b1;
        step();
        check("lock_escape", 32'(state_out), 32'h0001);
        first_hit = 0;
        for (int i = 1; i <= 65535; i++) begin
            step();
            if (state_out == 16'h0001 && first_hit == 0) first_hit = i;
        end
        enable = 1'b0;
        check("lfsr_period", 32'(first_hit), 32'd65535);

        // Overrun: second word dropped while the first is unread; set beats clear
        pulse_reset();
        mode     = 1'b0;
        rd_ready = 1'b0;
        enable   = 1'b1;
        steps(8);
        check("ovr_first_valid", 32'(rnd_valid), 32'h1);
        check("ovr_first_data", 32'(rnd_data), 32'hAA);
        check("ovr_none_yet", 32'(overrun), 32'h0);
        steps(7);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        enable    = 1'b0;
        check("ovr_set_wins", 32'(overrun), 32'h1);
        check("ovr_data_held", 32'(rnd_data), 32'hAA);
        check("ovr_valid_held", 32'(rnd_valid), 32'h1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'h0);
        rd_ready = 1'b1;
        step();
        check("ovr_drain", 32'(rnd_valid), 32'h0);

        // Completion on the same edge as a transfer
        pulse_reset();
        rd_ready = 1'b0;
        enable   = 1'b1;
        steps(8);
        check("xfer_first", 32'(rnd_data), 32'hAA);
        seed_load = 1'b1;
        seed      = 16'h0003;
        step();
        seed_load = 1'b0;
        check("xfer_seed_keeps", 32'(rnd_valid), 32'h1);
        steps(7);
        rd_ready = 1'b1;
        step();
        enable   = 1'b0;
        rd_ready = 1'b0;
        check("xfer_valid", 32'(rnd_valid), 32'h1);
        check("xfer_data", 32'(rnd_data), 32'h55);
        check("xfer_ovf", 32'(overrun), 32'h0);
        check("xfer_state", 32'(state_out), 32'h000B);

        // Asynchronous reset mid-word with a pending word
        pulse_reset();
        enable = 1'b1;
        steps(11);
        check("async_pre_valid", 32'(rnd_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_state", 32'(state_out), 32'h0);
        check("async_valid", 32'(rnd_valid), 32'h0);
        check("async_data", 32'(rnd_data), 32'h0);
        check("async_genbit", 32'(gen_bit), 32'h0);
        #1;
        rst_n = 1'b1;
        steps(8);
        enable = 1'b0;
        check("async_after_data", 32'(rnd_data), 32'hAA);
        check("async_after_valid", 32'(rnd_valid), 32'h1);
        check("async_after_state", 32'(state_out), 32'h0008);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
